// File: rtl/lap_pkg.sv
// Shared definitions for the lap recorder: digit width, BCD constants and
// the view FSM state type.
package lap_pkg;
    localparam int          DIGIT_W  = 4;
    localparam logic [3:0]  BCD_NINE = 4'd9;

    typedef enum logic {
        LIVE   = 1'b0,
        RECALL = 1'b1
    } view_state_t;
endpackage

// File: rtl/bcd_subtractor.sv
// Ripple BCD subtractor: y = a - b modulo 10^DIGITS. The final borrow is
// discarded, so the result wraps around like the stopwatch display does.
module bcd_subtractor
    import lap_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic [DIGIT_W*DIGITS-1:0] a,
    input  logic [DIGIT_W*DIGITS-1:0] b,
    output logic [DIGIT_W*DIGITS-1:0] y
);
    logic [DIGITS:0] brw;

    assign brw[0] = 1'b0;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        // 5-bit difference: bit 4 set means this digit went negative
        logic [4:0] diff;
        assign diff = {1'b0, a[g*DIGIT_W +: DIGIT_W]}
                    - {1'b0, b[g*DIGIT_W +: DIGIT_W]}
                    - {4'b0, brw[g]};
        assign brw[g+1] = diff[4];
        // a negative digit is corrected by adding ten and borrowing from the next digit
        assign y[g*DIGIT_W +: DIGIT_W] = diff[4] ? (diff[3:0] + (BCD_NINE + 4'd1))
                                                 : diff[3:0];
    end
endmodule

// File: rtl/lap_recorder.sv
// Lap recorder: captures stopwatch BCD times into a linear lap buffer and
// drives the hex decoders with either the live count or a recalled lap.
// Optional feature macro LAP_DELTA_EN: store split times (difference from
// the previous captured lap) instead of absolute times.
module lap_recorder
    import lap_pkg::*;
#(
    parameter  int DEPTH  = 8,
    parameter  int DIGITS = 4,
    localparam int IW     = $clog2(DEPTH),
    localparam int CW     = IW + 1,
    localparam int BW     = DIGIT_W * DIGITS
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [BW-1:0] live_bcd,
    input  logic          running,
    input  logic          lap_pulse,
    input  logic          view_next,
    input  logic          clear,
    output logic [BW-1:0] disp_bcd,
    output logic          disp_recall,
    output logic [IW-1:0] disp_index,
    output logic [CW-1:0] lap_count,
    output logic          overflow
);
    logic [BW-1:0] entry [DEPTH];
    view_state_t   state;
    logic          do_clr;
    logic          full;
    logic          cap;
    logic          at_last;
    logic [IW-1:0] nxt_idx;
    logic [BW-1:0] cap_val;

    assign do_clr  = rst | clear;
    assign full    = (lap_count == CW'(DEPTH));
    assign cap     = lap_pulse & running & ~full & ~do_clr;
    assign at_last = ({1'b0, disp_index} == (lap_count - CW'(1)));
    assign nxt_idx = disp_index + IW'(1);

`ifdef LAP_DELTA_EN
    logic [BW-1:0] prev_abs;

    bcd_subtractor #(.DIGITS(DIGITS)) u_sub (
        .a (live_bcd),
        .b (prev_abs),
        .y (cap_val)
    );

    // absolute time of the last stored lap; dropped laps leave it alone
    always_ff @(posedge clk) begin
        if (do_clr)   prev_abs <= '0;
        else if (cap) prev_abs <= live_bcd;
    end
`else
    assign cap_val = live_bcd;
`endif

    // lap storage: next free slot is always lap_count (buffer never wraps)
    always_ff @(posedge clk) begin
        if (cap) entry[lap_count[IW-1:0]] <= cap_val;
    end

    // stored-lap count and sticky overflow flag
    always_ff @(posedge clk) begin
        if (do_clr) begin
            lap_count <= '0;
            overflow  <= 1'b0;
        end else if (lap_pulse && running) begin
            if (full) overflow  <= 1'b1;
            else      lap_count <= lap_count + CW'(1);
        end
    end

    // view FSM with registered display outputs; wrap test uses pre-capture count
    always_ff @(posedge clk) begin
        if (do_clr) begin
            state       <= LIVE;
            disp_index  <= '0;
            disp_recall <= 1'b0;
            disp_bcd    <= '0;
        end else begin
            case (state)
                LIVE: begin
                    if (view_next && lap_count != '0) begin
                        state       <= RECALL;
                        disp_index  <= '0;
                        disp_recall <= 1'b1;
                        disp_bcd    <= entry[0];
                    end else begin
                        disp_recall <= 1'b0;
                        disp_bcd    <= live_bcd;
                    end
                end
                RECALL: begin
                    if (view_next && at_last) begin
                        state       <= LIVE;
                        disp_index  <= '0;
                        disp_recall <= 1'b0;
                        disp_bcd    <= live_bcd;
                    end else if (view_next) begin
                        disp_index  <= nxt_idx;
                        disp_recall <= 1'b1;
                        disp_bcd    <= entry[nxt_idx];
                    end else begin
                        disp_recall <= 1'b1;
                        disp_bcd    <= entry[disp_index];
                    end
                end
                default: begin
                    state       <= LIVE;
                    disp_index  <= '0;
                    disp_recall <= 1'b0;
                    disp_bcd    <= live_bcd;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lap_recorder.sv
// Randomized bench for lap_recorder against a queue-based lap model.
module tb_lap_recorder;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] live_bcd = '0;
    logic        running = 1'b0;
    logic        lap_pulse = 1'b0;
    logic        view_next = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] disp_bcd;
    logic        disp_recall;
    logic [2:0]  disp_index;
    logic [3:0]  lap_count;
    logic        overflow;

    int n_chk = 0;
    int n_err = 0;

    // behavioural model state
    int          laps[$];
    bit          m_view;
    int          m_idx;
    bit          m_ovf;
    int          m_prev;
    logic [15:0] m_disp;

    lap_recorder #(.DEPTH(DEPTH), .DIGITS(4)) dut (
        .clk(clk), .rst(rst), .live_bcd(live_bcd), .running(running),
        .lap_pulse(lap_pulse), .view_next(view_next), .clear(clear),
        .disp_bcd(disp_bcd), .disp_recall(disp_recall), .disp_index(disp_index),
        .lap_count(lap_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int bcd2int(input logic [15:0] b);
        return b[15:12] * 1000 + b[11:8] * 100 + b[7:4] * 10 + b[3:0];
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] r;
        r[3:0]   = 4'(v % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[15:12] = 4'((v / 1000) % 10);
        return r;
    endfunction

    function automatic logic [15:0] rnd_bcd();
        return int2bcd(int'($urandom_range(0, 9999)));
    endfunction

    task automatic model(input bit r, input bit run, input logic [15:0] lv,
                         input bit lp, input bit vn, input bit cl);
        int old_cnt;
        if (r || cl) begin
            laps.delete();
            m_view = 0; m_idx = 0; m_ovf = 0; m_prev = 0; m_disp = '0;
            return;
        end
        old_cnt = laps.size();
        if (lp && run) begin
            if (old_cnt < DEPTH) begin
`ifdef LAP_DELTA_EN
                laps.push_back((bcd2int(lv) - m_prev + 10000) % 10000);
                m_prev = bcd2int(lv);
`else
                laps.push_back(bcd2int(lv));
`endif
            end else begin
                m_ovf = 1;
            end
        end
        if (vn) begin
            if (!m_view) begin
                if (old_cnt > 0) begin m_view = 1; m_idx = 0; end
            end else if (m_idx == old_cnt - 1) begin
                m_view = 0; m_idx = 0;
            end else begin
                m_idx++;
            end
        end
        m_disp = m_view ? int2bcd(laps[m_idx]) : lv;
    endtask

    task automatic step(input bit r, input bit run, input logic [15:0] lv,
                        input bit lp, input bit vn, input bit cl);
        rst = r; running = run; live_bcd = lv;
        lap_pulse = lp; view_next = vn; clear = cl;
        @(posedge clk);
        model(r, run, lv, lp, vn, cl);
        #1;
        chk("disp_bcd",    32'(disp_bcd),    32'(m_disp));
        chk("disp_recall", 32'(disp_recall), 32'(m_view));
        chk("disp_index",  32'(disp_index),  32'(m_idx));
        chk("lap_count",   32'(lap_count),   32'(laps.size()));
        chk("overflow",    32'(overflow),    32'(m_ovf));
    endtask

    initial begin
        // reset
        step(1, 0, 16'h0000, 0, 0, 0);
        step(1, 1, 16'h1234, 1, 1, 0);
        // two laps, page through them and back to live
        step(0, 1, 16'h0123, 1, 0, 0);
        step(0, 1, 16'h0456, 1, 0, 0);
        step(0, 1, 16'h0500, 0, 1, 0);
        step(0, 1, 16'h0501, 0, 0, 0);
        step(0, 1, 16'h0502, 0, 1, 0);
        step(0, 1, 16'h0503, 0, 1, 0);
        step(0, 1, 16'h0504, 0, 0, 0);
        // wrap while capturing: at last index, lap+view together
        step(0, 1, 16'h0600, 0, 1, 0);
        step(0, 1, 16'h0601, 0, 1, 0);
        step(0, 1, 16'h0777, 1, 1, 0);
        step(0, 1, 16'h0778, 0, 1, 0);
        // fill to full and overflow
        for (int i = 0; i < 7; i++) step(0, 1, int2bcd(1000 + i * 111), 1, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 16'h9999, 0, 1, 0);
        step(0, 1, 16'h0000, 0, 0, 1);
        // lap while stopped, then lap+clear
        step(0, 0, 16'h0321, 1, 0, 0);
        step(0, 1, 16'h0322, 1, 0, 1);
        step(0, 1, 16'h0323, 0, 1, 0);
`ifdef LAP_DELTA_EN
        step(0, 1, 16'h0000, 0, 0, 1);
        step(0, 1, 16'h9990, 1, 0, 0);
        step(0, 1, 16'h0010, 1, 0, 0);
        step(0, 1, 16'h0011, 0, 1, 0);
        step(0, 1, 16'h0012, 0, 1, 0);
`endif
        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 5) != 0),
                 rnd_bcd(),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 49) == 0));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule
